// File: rtl/game_sequencer_pkg.sv
// rtl/game_sequencer_pkg.sv - shared states, coin types and game defaults
package game_sequencer_pkg;

   localparam int DEF_GAME_COST  = 4;
   localparam int DEF_MAX_GAMES  = 7;
   localparam int DEF_MAX_ROUNDS = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_MASTER,
      S_GUESS,
      S_GRADE,
      S_WON,
      S_LOST
   } state_t;

   typedef enum logic [1:0] {
      COIN_NONE     = 2'b00,
      COIN_CIRCLE   = 2'b01,
      COIN_TRIANGLE = 2'b10,
      COIN_PENTAGON = 2'b11
   } coin_t;

   function automatic logic [2:0] coin_credits(input coin_t c);
      case (c)
         COIN_CIRCLE:   return 3'd1;
         COIN_TRIANGLE: return 3'd3;
         COIN_PENTAGON: return 3'd5;
         default:       return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_bank.sv
// rtl/coin_bank.sv - credit accumulator and banked-game counter
module coin_bank
   import game_sequencer_pkg::*;
#(
   parameter int GAME_COST = DEF_GAME_COST,
   parameter int MAX_GAMES = DEF_MAX_GAMES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       coin_inserted_i,
   input  logic [1:0] coin_value_i,
   input  logic       dec_i,
   output logic [3:0] num_games_o,
   output logic       load_num_games_o
);

   logic [2:0] credits_q, credits_d;
   logic [3:0] num_games_q, num_games_d;
   logic       load_q, load_d;
   logic [3:0] after_dec;
   logic [3:0] sum;
   logic [3:0] rem;

   // Saturation is judged after the game-start decrement so a coin landing
   // on the same cycle as StartGame is never lost.
   always_comb begin
      after_dec   = num_games_q - {3'b000, dec_i};
      sum         = {1'b0, credits_q};
      rem         = '0;
      credits_d   = credits_q;
      num_games_d = after_dec;
      load_d      = dec_i;
      if (after_dec < 4'(MAX_GAMES)) begin
         if (coin_inserted_i)
            sum = sum + {1'b0, coin_credits(coin_t'(coin_value_i))};
         if (sum >= 4'(GAME_COST)) begin
            rem         = sum - 4'(GAME_COST);
            credits_d   = rem[2:0];
            num_games_d = after_dec + 4'd1;
            load_d      = 1'b1;
         end else begin
            credits_d = sum[2:0];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         credits_q   <= '0;
         num_games_q <= '0;
         load_q      <= 1'b0;
      end else begin
         credits_q   <= credits_d;
         num_games_q <= num_games_d;
         load_q      <= load_d;
      end
   end

   assign num_games_o      = num_games_q;
   assign load_num_games_o = load_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game control FSM, round counter and master-pattern load
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int GAME_COST  = DEF_GAME_COST,
   parameter int MAX_GAMES  = DEF_MAX_GAMES,
   parameter int MAX_ROUNDS = DEF_MAX_ROUNDS
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] CoinValue,
   input  logic       CoinInserted,
   input  logic       StartGame,
   input  logic       LoadShapeNow,
   input  logic [1:0] ShapeLocation,
   input  logic       GradeIt,
   input  logic       gradeDone,
   input  logic [3:0] Znarly,
   input  logic       debug,
   output logic [3:0] NumGames,
   output logic [3:0] RoundNumber,
   output logic       GameWon,
   output logic       loadNumGames,
   output logic       loadGuess,
   output logic       loadZnarlyZood,
   output logic       loadShape,
   output logic       gradeStart,
   output logic       displayMasterPattern
);

   state_t     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       won_q, won_d;
   logic [3:0] mask_q, mask_d;
   logic       dec;

   coin_bank #(
      .GAME_COST(GAME_COST),
      .MAX_GAMES(MAX_GAMES)
   ) u_bank (
      .clock           (clock),
      .reset           (reset),
      .coin_inserted_i (CoinInserted),
      .coin_value_i    (CoinValue),
      .dec_i           (dec),
      .num_games_o     (NumGames),
      .load_num_games_o(loadNumGames)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         round_q <= '0;
         won_q   <= 1'b0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         won_q   <= won_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      won_d          = won_q;
      mask_d         = mask_q;
      dec            = 1'b0;
      loadShape      = 1'b0;
      loadGuess      = 1'b0;
      gradeStart     = 1'b0;
      loadZnarlyZood = 1'b0;
      if (reset) begin
         unique case (state_q)
            S_IDLE, S_WON, S_LOST: begin
               if (StartGame && NumGames != 4'd0) begin
                  state_d = S_LOAD_MASTER;
                  dec     = 1'b1;
                  won_d   = 1'b0;
                  mask_d  = '0;
                  round_d = '0;
               end
            end
            S_LOAD_MASTER: begin
               if (mask_q == 4'hF) begin
                  state_d = S_GUESS;
                  round_d = 4'd1;
               end
               if (LoadShapeNow) begin
                  loadShape = 1'b1;
                  mask_d    = mask_q | (4'b0001 << ShapeLocation);
               end
            end
            S_GUESS: begin
               if (GradeIt) begin
                  state_d    = S_GRADE;
                  loadGuess  = 1'b1;
                  gradeStart = 1'b1;
               end
            end
            S_GRADE: begin
               if (gradeDone) begin
                  loadZnarlyZood = 1'b1;
                  if (Znarly == 4'd4) begin
                     state_d = S_WON;
                     won_d   = 1'b1;
                  end else if (round_q == 4'(MAX_ROUNDS)) begin
                     state_d = S_LOST;
                  end else begin
                     state_d = S_GUESS;
                     round_d = round_q + 4'd1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign RoundNumber          = round_q;
   assign GameWon              = won_q;
   assign displayMasterPattern = debug | (reset & (state_q == S_WON || state_q == S_LOST));

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;
   import game_sequencer_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] CoinValue = 2'b00;
   logic       CoinInserted = 1'b0;
   logic       StartGame = 1'b0;
   logic       LoadShapeNow = 1'b0;
   logic [1:0] ShapeLocation = 2'b00;
   logic       GradeIt = 1'b0;
   logic       gradeDone = 1'b0;
   logic [3:0] Znarly = 4'd0;
   logic       debug = 1'b0;
   logic [3:0] NumGames;
   logic [3:0] RoundNumber;
   logic       GameWon;
   logic       loadNumGames;
   logic       loadGuess;
   logic       loadZnarlyZood;
   logic       loadShape;
   logic       gradeStart;
   logic       displayMasterPattern;

   int total = 0;
   int bad   = 0;

   game_sequencer dut (
      .clock               (clock),
      .reset               (reset),
      .CoinValue           (CoinValue),
      .CoinInserted        (CoinInserted),
      .StartGame           (StartGame),
      .LoadShapeNow        (LoadShapeNow),
      .ShapeLocation       (ShapeLocation),
      .GradeIt             (GradeIt),
      .gradeDone           (gradeDone),
      .Znarly              (Znarly),
      .debug               (debug),
      .NumGames            (NumGames),
      .RoundNumber         (RoundNumber),
      .GameWon             (GameWon),
      .loadNumGames        (loadNumGames),
      .loadGuess           (loadGuess),
      .loadZnarlyZood      (loadZnarlyZood),
      .loadShape           (loadShape),
      .gradeStart          (gradeStart),
      .displayMasterPattern(displayMasterPattern)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic coin(input logic [1:0] v, input int games, input int cred, input int load);
      CoinValue    = v;
      CoinInserted = 1'b1;
      step();
      CoinInserted = 1'b0;
      CoinValue    = 2'b00;
      chk("coin_games", int'(NumGames), games);
      chk("coin_credits", int'(dut.u_bank.credits_q), cred);
      chk("coin_load", int'(loadNumGames), load);
   endtask

   task automatic quiet(input int games, input int cred);
      step();
      chk("quiet_load", int'(loadNumGames), 0);
      chk("quiet_games", int'(NumGames), games);
      chk("quiet_credits", int'(dut.u_bank.credits_q), cred);
   endtask

   task automatic start_game(input int games_after);
      StartGame = 1'b1;
      step();
      StartGame = 1'b0;
      chk("start_state", int'(dut.state_q), int'(S_LOAD_MASTER));
      chk("start_games", int'(NumGames), games_after);
      chk("start_load", int'(loadNumGames), 1);
      chk("start_round", int'(RoundNumber), 0);
      chk("start_won", int'(GameWon), 0);
   endtask

   task automatic shape(input logic [1:0] s);
      LoadShapeNow  = 1'b1;
      ShapeLocation = s;
      #1;
      chk("shape_pulse", int'(loadShape), 1);
      step();
      LoadShapeNow = 1'b0;
      #1;
      chk("shape_off", int'(loadShape), 0);
   endtask

   task automatic load_all();
      for (int s = 0; s < 4; s++) shape(2'(s));
      chk("master_hold", int'(dut.state_q), int'(S_LOAD_MASTER));
      step();
      chk("guess_state", int'(dut.state_q), int'(S_GUESS));
      chk("guess_round", int'(RoundNumber), 1);
   endtask

   task automatic grade(input logic [3:0] z, input int wait_cycles);
      GradeIt = 1'b1;
      #1;
      chk("grade_start", int'(gradeStart), 1);
      chk("grade_guess", int'(loadGuess), 1);
      step();
      GradeIt = 1'b0;
      #1;
      chk("grade_start_off", int'(gradeStart), 0);
      chk("grade_state", int'(dut.state_q), int'(S_GRADE));
      for (int i = 1; i < wait_cycles; i++) step();
      gradeDone = 1'b1;
      Znarly    = z;
      #1;
      chk("grade_zz", int'(loadZnarlyZood), 1);
      step();
      gradeDone = 1'b0;
      #1;
      chk("grade_zz_off", int'(loadZnarlyZood), 0);
   endtask

   initial begin
      debug = 1'b1;
      step();
      step();
      chk("rst_disp_debug", int'(displayMasterPattern), 1);
      debug = 1'b0;
      #1;
      chk("rst_disp", int'(displayMasterPattern), 0);
      chk("rst_state", int'(dut.state_q), int'(S_IDLE));
      chk("rst_games", int'(NumGames), 0);
      chk("rst_round", int'(RoundNumber), 0);
      chk("rst_won", int'(GameWon), 0);
      chk("rst_load", int'(loadNumGames), 0);
      reset = 1'b1;

      // Empty coin and StartGame with no banked games are both ignored
      coin(2'b00, 0, 0, 0);
      StartGame = 1'b1;
      step();
      StartGame = 1'b0;
      chk("start_ignored", int'(dut.state_q), int'(S_IDLE));

      coin(2'b10, 0, 3, 0);
      coin(2'b01, 1, 0, 1);
      quiet(1, 0);
      coin(2'b11, 2, 1, 1);
      quiet(2, 1);
      coin(2'b11, 3, 2, 1);
      quiet(3, 2);
      coin(2'b11, 4, 3, 1);
      quiet(4, 3);
      coin(2'b11, 5, 4, 1);
      step();
      chk("late_convert_games", int'(NumGames), 6);
      chk("late_convert_cred", int'(dut.u_bank.credits_q), 0);
      chk("late_convert_load", int'(loadNumGames), 1);
      quiet(6, 0);
      coin(2'b11, 7, 1, 1);
      quiet(7, 1);
      coin(2'b11, 7, 1, 0);
      quiet(7, 1);

      // Coin and StartGame together: 7-1 leaves room, 1+5 converts back to 7
      CoinValue    = 2'b11;
      CoinInserted = 1'b1;
      start_game(7);
      CoinInserted = 1'b0;
      CoinValue    = 2'b00;
      chk("both_credits", int'(dut.u_bank.credits_q), 2);

      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("rst2_games", int'(NumGames), 0);
      chk("rst2_credits", int'(dut.u_bank.credits_q), 0);
      coin(2'b10, 0, 3, 0);
      coin(2'b01, 1, 0, 1);
      quiet(1, 0);
      start_game(0);
      shape(2'd0);
      shape(2'd0);
      shape(2'd1);
      shape(2'd2);
      shape(2'd3);
      chk("master_hold5", int'(dut.state_q), int'(S_LOAD_MASTER));
      step();
      chk("guess_state5", int'(dut.state_q), int'(S_GUESS));
      chk("guess_round5", int'(RoundNumber), 1);
      chk("guess_disp", int'(displayMasterPattern), 0);
      debug = 1'b1;
      #1;
      chk("guess_disp_debug", int'(displayMasterPattern), 1);
      debug = 1'b0;

      grade(4'd4, 5);
      chk("win_state", int'(dut.state_q), int'(S_WON));
      chk("win_flag", int'(GameWon), 1);
      chk("win_disp", int'(displayMasterPattern), 1);

      coin(2'b10, 0, 3, 0);
      coin(2'b01, 1, 0, 1);
      quiet(1, 0);
      start_game(0);
      chk("restart_disp", int'(displayMasterPattern), 0);
      load_all();
      for (int r = 1; r <= 8; r++) begin
         chk("loss_round", int'(RoundNumber), r);
         grade(4'd2, 1);
         chk("loss_state", int'(dut.state_q), (r < 8) ? int'(S_GUESS) : int'(S_LOST));
      end
      chk("lost_round", int'(RoundNumber), 8);
      chk("lost_won", int'(GameWon), 0);
      chk("lost_disp", int'(displayMasterPattern), 1);

      reset = 1'b0;
      #1;
      chk("rst_lost_disp", int'(displayMasterPattern), 0);
      step();
      reset = 1'b1;
      chk("rst_lost_state", int'(dut.state_q), int'(S_IDLE));

      coin(2'b10, 0, 3, 0);
      coin(2'b01, 1, 0, 1);
      quiet(1, 0);
      start_game(0);
      load_all();
      GradeIt = 1'b1;
      step();
      GradeIt = 1'b0;
      chk("pre_rst_state", int'(dut.state_q), int'(S_GRADE));
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("grade_rst_state", int'(dut.state_q), int'(S_IDLE));
      chk("grade_rst_round", int'(RoundNumber), 0);
      chk("grade_rst_won", int'(GameWon), 0);
      chk("grade_rst_games", int'(NumGames), 0);
      chk("grade_rst_mask", int'(dut.mask_q), 0);
      chk("grade_rst_load", int'(loadNumGames), 0);
      gradeDone = 1'b1;
      Znarly    = 4'd4;
      #1;
      chk("late_done_zz", int'(loadZnarlyZood), 0);
      step();
      gradeDone = 1'b0;
      chk("late_done_state", int'(dut.state_q), int'(S_IDLE));
      chk("late_done_won", int'(GameWon), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
